// File: rtl/mod_reduce_seq_if.sv
// Operand/result handshake bundle for mod_reduce_seq.
// The upstream side (multiplier plus result consumer) uses the master view,
// and the reducer uses the slave view.
interface mod_reduce_seq_if #(
  parameter int DATA_SIZE = 32
);

  // Operand channel: an unsigned product and the modulus to reduce it by.
  logic [2*DATA_SIZE-1:0] prod;
  logic [DATA_SIZE-1:0]   q;
  logic                   in_valid;
  logic                   in_ready;

  // Result channel: the remainder and a flag that marks a zero modulus.
  logic [DATA_SIZE-1:0]   rem;
  logic                   err;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output prod,
    output q,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  rem,
    input  err,
    input  out_valid
  );

  modport slave (
    input  prod,
    input  q,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output rem,
    output err,
    output out_valid
  );

endinterface

// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: rem = prod mod q.
// A restoring long division walks the product one bit per cycle, MSB first,
// while it keeps a partial remainder that is never allowed to reach q.
// A zero modulus skips the division and returns rem=0 with err=1.
module mod_reduce_seq #(
  parameter int DATA_SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  mod_reduce_seq_if.slave   bus
);

  localparam int PROD_W = 2 * DATA_SIZE;
  localparam int CNT_W  = $clog2(PROD_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PROD_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operands. The product is shifted left once per CALC cycle, so
  // its MSB is always the next dividend bit.
  logic [PROD_W-1:0]    prod_sh;
  logic [DATA_SIZE-1:0] q_reg;

  // The partial remainder carries one extra bit. It stays below q, so the
  // shifted value (r<<1)|bit is at most 2q-1 and always fits.
  logic [DATA_SIZE:0]   r;
  logic [CNT_W-1:0]     cnt;

  logic [DATA_SIZE-1:0] rem_reg;
  logic                 err_reg;

  logic                 in_ready_c;
  logic                 out_valid_c;
  logic                 accept;
  logic                 last_bit;
  logic                 q_zero;
  logic [DATA_SIZE:0]   r_shift;
  logic [DATA_SIZE:0]   r_next;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign last_bit = (cnt == LAST_CNT);
  assign q_zero   = (bus.q == '0);

  // Single division step: bring in the next bit, then subtract q if the
  // partial remainder has reached it.
  always_comb begin
    r_shift = {r[DATA_SIZE-1:0], prod_sh[PROD_W-1]};
    if (r_shift >= {1'b0, q_reg}) begin
      r_next = r_shift - {1'b0, q_reg};
    end else begin
      r_next = r_shift;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of the order of the blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = q_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and division datapath. Operands are captured only on
  // an accept, so upstream changes outside IDLE have no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_sh <= '0;
      q_reg   <= '0;
      r       <= '0;
      cnt     <= '0;
    end else if (accept) begin
      prod_sh <= bus.prod;
      q_reg   <= bus.q;
      r       <= '0;
      cnt     <= '0;
    end else if (state == CALC) begin
      prod_sh <= prod_sh << 1;
      r       <= r_next;
      cnt     <= cnt + 1'b1;
    end
  end

  // Result registers. They change only when a new result is produced and
  // otherwise hold their last value; out_valid alone says when they count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_reg <= '0;
      err_reg <= 1'b0;
    end else if (accept && q_zero) begin
      rem_reg <= '0;
      err_reg <= 1'b1;
    end else if ((state == CALC) && last_bit) begin
      rem_reg <= r_next[DATA_SIZE-1:0];
      err_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.rem       = rem_reg;
  assign bus.err       = err_reg;

endmodule
